// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, control-token table and receiver lock states.
// The token table must stay identical to the transmit-side encoder's table.
package tmds_pkg;

    localparam int unsigned WordWidth = 10;

    // Control tokens as w[9:0]; bit 0 is the first bit on the wire.
    localparam logic [WordWidth-1:0] TokenC00 = 10'b0010101011;
    localparam logic [WordWidth-1:0] TokenC01 = 10'b1101010100;
    localparam logic [WordWidth-1:0] TokenC10 = 10'b0010101010;
    localparam logic [WordWidth-1:0] TokenC11 = 10'b1101010101;

    typedef enum logic [0:0] {
        StSearch,
        StLocked
    } dec_state_e;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS word decoder: classifies a 10-bit word as control token or data
// and recovers C1/C0 or the 8-bit pixel byte.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [WordWidth-1:0] word_i,
    output logic                 is_token_o,
    output logic                 c1_o,
    output logic                 c0_o,
    output logic [7:0]           d_o
);

    logic [7:0] x;

    always_comb begin
        is_token_o = 1'b1;
        c1_o       = 1'b0;
        c0_o       = 1'b0;
        case (word_i)
            TokenC00: begin
                c1_o = 1'b0;
                c0_o = 1'b0;
            end
            TokenC01: begin
                c1_o = 1'b0;
                c0_o = 1'b1;
            end
            TokenC10: begin
                c1_o = 1'b1;
                c0_o = 1'b0;
            end
            TokenC11: begin
                c1_o = 1'b1;
                c0_o = 1'b1;
            end
            default: is_token_o = 1'b0;
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain selected by bit 8.
    always_comb begin
        x      = word_i[9] ? ~word_i[7:0] : word_i[7:0];
        d_o    = 8'h00;
        d_o[0] = x[0];
        for (int i = 1; i < 8; i++) begin
            d_o[i] = word_i[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Single-lane DVI TMDS receiver: bit deserializer, token-based word alignment and decode.
// Optional lock-loss counter output err_cnt is built when TMDS_DEC_ERR_CNT_EN is defined.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 8,
    parameter int unsigned MAX_DATA_RUN = 4096
) (
    input  logic        tmds_clk,
    input  logic        rst,
    input  logic        serial_in,
    output logic        word_valid,
    output logic        de,
    output logic [7:0]  d,
    output logic        c0,
    output logic        c1,
    output logic        locked
`ifdef TMDS_DEC_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned           DataRunW = $clog2(MAX_DATA_RUN + 1);
    localparam logic [DataRunW-1:0]   MaxRun   = DataRunW'(MAX_DATA_RUN);
    localparam logic [7:0]            LockCnt  = 8'(LOCK_COUNT);
    localparam logic [3:0]            SinceMax = 4'd11;

    logic [WordWidth-1:0] w_q, w_d;
    dec_state_e           state_q, state_d;
    logic [3:0]           since_q, since_d, since_inc;
    logic [7:0]           run_q, run_d, run_nxt;
    logic [3:0]           wcnt_q, wcnt_d;
    logic [DataRunW-1:0]  data_run_q, data_run_d, data_run_inc;
    logic                 wv_q, wv_d;
    logic                 de_q, de_d;
    logic [7:0]           d_q, d_d;
    logic                 c0_q, c0_d;
    logic                 c1_q, c1_d;
    logic                 locked_q, locked_d;

    logic                 tok;
    logic                 tok_c1;
    logic                 tok_c0;
    logic [7:0]           dec_d;

    tmds_word_decode u_word_decode (
        .word_i     (w_q),
        .is_token_o (tok),
        .c1_o       (tok_c1),
        .c0_o       (tok_c0),
        .d_o        (dec_d)
    );

    always_comb begin
        w_d          = {serial_in, w_q[WordWidth-1:1]};
        state_d      = state_q;
        since_d      = since_q;
        run_d        = run_q;
        wcnt_d       = wcnt_q;
        data_run_d   = data_run_q;
        wv_d         = 1'b0;
        de_d         = de_q;
        d_d          = d_q;
        c0_d         = c0_q;
        c1_d         = c1_q;
        locked_d     = locked_q;
        // since_inc is the edge count including this one, so a token exactly one word
        // after the previous token sees since_inc == 10.
        since_inc    = (since_q == SinceMax) ? SinceMax : since_q + 4'd1;
        run_nxt      = (since_inc == 4'd10) ? run_q + 8'd1 : 8'd1;
        data_run_inc = data_run_q + DataRunW'(1);

        unique case (state_q)
            StSearch: begin
                if (tok) begin
                    since_d = 4'd0;
                    run_d   = run_nxt;
                    if (run_nxt == LockCnt) begin
                        state_d    = StLocked;
                        wcnt_d     = 4'd1;
                        data_run_d = '0;
                        locked_d   = 1'b1;
                    end
                end else begin
                    since_d = since_inc;
                    if (since_inc == 4'd10) begin
                        run_d = 8'd0;
                    end
                end
            end
            StLocked: begin
                wcnt_d = (wcnt_q == 4'd9) ? 4'd0 : wcnt_q + 4'd1;
                if (wcnt_q == 4'd0) begin
                    if (tok) begin
                        wv_d       = 1'b1;
                        de_d       = 1'b0;
                        c1_d       = tok_c1;
                        c0_d       = tok_c0;
                        data_run_d = '0;
                    end else if (data_run_inc == MaxRun) begin
                        // Too long without a token: alignment is presumed lost.
                        state_d    = StSearch;
                        locked_d   = 1'b0;
                        run_d      = 8'd0;
                        since_d    = 4'd0;
                        data_run_d = '0;
                    end else begin
                        wv_d       = 1'b1;
                        de_d       = 1'b1;
                        d_d        = dec_d;
                        data_run_d = data_run_inc;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge tmds_clk) begin
        if (rst) begin
            w_q        <= '0;
            state_q    <= StSearch;
            since_q    <= 4'd0;
            run_q      <= 8'd0;
            wcnt_q     <= 4'd0;
            data_run_q <= '0;
            wv_q       <= 1'b0;
            de_q       <= 1'b0;
            d_q        <= 8'h00;
            c0_q       <= 1'b0;
            c1_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            w_q        <= w_d;
            state_q    <= state_d;
            since_q    <= since_d;
            run_q      <= run_d;
            wcnt_q     <= wcnt_d;
            data_run_q <= data_run_d;
            wv_q       <= wv_d;
            de_q       <= de_d;
            d_q        <= d_d;
            c0_q       <= c0_d;
            c1_q       <= c1_d;
            locked_q   <= locked_d;
        end
    end

    assign word_valid = wv_q;
    assign de         = de_q;
    assign d          = d_q;
    assign c0         = c0_q;
    assign c1         = c1_q;
    assign locked     = locked_q;

`ifdef TMDS_DEC_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic        err_inc;

    // The only LOCKED -> SEARCH path is the data-run timeout.
    assign err_inc = (state_q == StLocked) && (state_d == StSearch);

    always_ff @(posedge tmds_clk) begin
        if (rst) begin
            err_cnt_q <= 16'h0000;
        end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'h0001;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: expected words are queued as they are sent
// and compared whenever the decoder strobes word_valid.
module tb_tmds_channel_decoder;

    localparam int unsigned LockCount  = 8;
    localparam int unsigned MaxDataRun = 16;

    localparam logic [9:0] TokC00 = 10'b0010101011;
    localparam logic [9:0] TokC01 = 10'b1101010100;
    localparam logic [9:0] TokC10 = 10'b0010101010;
    localparam logic [9:0] TokC11 = 10'b1101010101;

    typedef struct packed {
        logic       de;
        logic [7:0] d;
        logic       c1;
        logic       c0;
    } word_exp_t;

    logic        tmds_clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic        word_valid;
    logic        de;
    logic [7:0]  d;
    logic        c0;
    logic        c1;
    logic        locked;
`ifdef TMDS_DEC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    word_exp_t   sb_q[$];
    logic [7:0]  last_d;
    logic        last_c1;
    logic        last_c0;
    int unsigned cyc = 0;
    int unsigned last_wv_cyc = 0;
    bit          have_wv = 1'b0;

    always #5 tmds_clk = ~tmds_clk;

    tmds_channel_decoder #(
        .LOCK_COUNT   (LockCount),
        .MAX_DATA_RUN (MaxDataRun)
    ) dut (
        .tmds_clk   (tmds_clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .word_valid (word_valid),
        .de         (de),
        .d          (d),
        .c0         (c0),
        .c1         (c1),
        .locked     (locked)
`ifdef TMDS_DEC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference 8b/10b data encoder; inv selects the DC-balance inversion directly.
    function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic inv);
        logic [8:0] qm;
        int         n1;
        n1    = $countones(b);
        qm[0] = b[0];
        if (n1 > 4 || (n1 == 4 && !b[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge tmds_clk);
        #1;
    endtask

    task automatic send_word(input logic [9:0] wrd);
        for (int i = 0; i < 10; i++) send_bit(wrd[i]);
    endtask

    task automatic push_token(input logic t1, input logic t0);
        word_exp_t e;
        last_c1 = t1;
        last_c0 = t0;
        e = '{de: 1'b0, d: last_d, c1: t1, c0: t0};
        sb_q.push_back(e);
    endtask

    task automatic push_data(input logic [7:0] b);
        word_exp_t e;
        last_d = b;
        e = '{de: 1'b1, d: b, c1: last_c1, c0: last_c0};
        sb_q.push_back(e);
    endtask

    task automatic do_reset(input int unsigned n);
        rst       = 1'b1;
        serial_in = 1'b0;
        repeat (n) @(posedge tmds_clk);
        #1;
        rst     = 1'b0;
        last_d  = 8'h00;
        last_c1 = 1'b0;
        last_c0 = 1'b0;
    endtask

    // One more edge lets the last queued word be evaluated, then wait for the monitor.
    task automatic drain(input string tag);
        send_bit(1'b0);
        @(negedge tmds_clk);
        #1;
        check_eq(tag, 32'(sb_q.size()), 32'd0);
    endtask

    always @(posedge tmds_clk) cyc <= cyc + 1;

    always @(negedge tmds_clk) begin
        if (rst) begin
            have_wv = 1'b0;
        end else if (word_valid) begin
            if (have_wv && (cyc - last_wv_cyc) <= 20) begin
                check_eq("wv_period", cyc - last_wv_cyc, 32'd10);
            end
            have_wv     = 1'b1;
            last_wv_cyc = cyc;
            if (sb_q.size() == 0) begin
                check_eq("wv_unexpected", 32'(word_valid), 32'd0);
            end else begin
                check_eq("word", 32'({de, d, c1, c0}), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] b;
        logic       inv;

        // 1: reset, then a long idle stream never locks.
        do_reset(3);
        check_eq("rst_wv", 32'(word_valid), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_de", 32'(de), 32'd0);
        check_eq("rst_d", 32'(d), 32'd0);
        check_eq("rst_c1c0", 32'({c1, c0}), 32'd0);
`ifdef TMDS_DEC_ERR_CNT_EN
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        repeat (100) send_bit(1'b0);
        check_eq("idle_locked", 32'(locked), 32'd0);
        check_eq("idle_out", 32'({word_valid, de, d, c1, c0}), 32'd0);

        // 2: eight C01 tokens lock; further tokens decode every 10 cycles.
        repeat (LockCount) send_word(TokC01);
        check_eq("lock_not_yet", 32'(locked), 32'd0);
        push_token(1'b0, 1'b1);
        send_word(TokC01);
        check_eq("lock_rise", 32'(locked), 32'd1);
        repeat (3) begin
            push_token(1'b0, 1'b1);
            send_word(TokC01);
        end

        // 3: data decode, both inversion polarities, then the other tokens.
        push_data(8'h00);
        send_word(10'b0100000000);
        push_data(8'hFE);
        send_word(10'b1011111111);
        for (int i = 0; i < 6; i++) begin
            b   = 8'($urandom_range(0, 255));
            inv = 1'($urandom_range(0, 1));
            push_data(b);
            send_word(tmds_enc(b, inv));
        end
        push_token(1'b1, 1'b0);
        send_word(TokC10);
        push_token(1'b1, 1'b1);
        send_word(TokC11);
        push_data(8'hA5);
        send_word(tmds_enc(8'hA5, 1'b1));
        push_token(1'b0, 1'b0);
        send_word(TokC00);
        check_eq("still_locked", 32'(locked), 32'd1);
        drain("sb_empty_t3");

        // 4: a data word breaks the token run; lock needs a full fresh run.
        do_reset(3);
        repeat (LockCount - 1) send_word(TokC01);
        check_eq("run7_locked", 32'(locked), 32'd0);
        send_word(10'b0100000000);
        check_eq("break_locked", 32'(locked), 32'd0);
        repeat (LockCount) send_word(TokC01);
        check_eq("run2_not_yet", 32'(locked), 32'd0);
        push_token(1'b0, 1'b1);
        send_word(TokC01);
        check_eq("run2_locked", 32'(locked), 32'd1);

        // 5: slip one bit; every misaligned 0x00 word reads as 1000000000 -> d=0xFF.
        send_bit(1'b0);
        for (int i = 1; i <= int'(MaxDataRun); i++) begin
            if (i < int'(MaxDataRun)) push_data(8'hFF);
            send_word(10'b0100000000);
            if (i == int'(MaxDataRun) - 1) check_eq("run15_locked", 32'(locked), 32'd1);
        end
        check_eq("timeout_unlock", 32'(locked), 32'd0);
`ifdef TMDS_DEC_ERR_CNT_EN
        check_eq("err_cnt", 32'(err_cnt), 32'd1);
`endif
        repeat (LockCount) send_word(TokC01);
        check_eq("relock_not_yet", 32'(locked), 32'd0);
        push_token(1'b0, 1'b1);
        send_word(TokC01);
        check_eq("relock", 32'(locked), 32'd1);

        // 6: one-cycle reset mid-word drops lock immediately.
        for (int i = 0; i < 5; i++) send_bit(TokC11[i]);
        check_eq("pre_rst_locked", 32'(locked), 32'd1);
        check_eq("sb_empty_t5", 32'(sb_q.size()), 32'd0);
        rst = 1'b1;
        @(posedge tmds_clk);
        #1;
        check_eq("mid_rst_locked", 32'(locked), 32'd0);
        check_eq("mid_rst_wv", 32'(word_valid), 32'd0);
`ifdef TMDS_DEC_ERR_CNT_EN
        check_eq("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst     = 1'b0;
        last_d  = 8'h00;
        last_c1 = 1'b0;
        last_c0 = 1'b0;
        repeat (LockCount) send_word(TokC11);
        check_eq("post_rst_not_yet", 32'(locked), 32'd0);
        push_token(1'b1, 1'b0);
        send_word(TokC10);
        check_eq("post_rst_locked", 32'(locked), 32'd1);
        push_token(1'b0, 1'b0);
        send_word(TokC00);
        drain("sb_empty_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Single-channel DVI TMDS receiver: deserializes one TMDS lane, finds 10-bit word alignment from control tokens, and decodes each word into 8-bit pixel data or the C1/C0 control pair with a data-enable flag. It is the receive-side counterpart of the team's per-channel 8b/10b encoder and shift-out path. It sits directly behind the lane input buffer and feeds video-timing recovery.

## Interface
Parameters:
- LOCK_COUNT, 8: consecutive correctly spaced control tokens needed to declare lock (range 2..255).
- MAX_DATA_RUN, 4096: consecutive non-token words after which lock is dropped (range 16..8191; must exceed one active line).

Ports:
- tmds_clk  in  1  serial bit clock; one TMDS bit per rising edge.
- rst  in  1  synchronous, active-high reset.
- serial_in  in  1  recovered lane bit; the first bit of each word is word bit 0.
- word_valid  out  1  one-cycle strobe per decoded word.
- de  out  1  1 = data word, 0 = control token.
- d  out  8  decoded pixel byte; valid with word_valid when de=1.
- c0  out  1  decoded control bit C0 (hSync on the blue lane).
- c1  out  1  decoded control bit C1 (vSync on the blue lane).
- locked  out  1  word alignment established.
- err_cnt  out  16  lock-loss counter; present only with TMDS_DEC_ERR_CNT_EN.

## Operation
- Window: 10-bit shift register w, w <= {serial_in, w[9:1]} every edge. After 10 bits, w[0] holds the earliest bit.
- Token match uses the team transmitter's table, w[9:0]:
  - 0010101011 → C1C0=00
  - 1101010100 → C1C0=01
  - 0010101010 → C1C0=10
  - 1101010101 → C1C0=11
- SEARCH state:
  - since: counts edges since the last match, saturating at 11.
  - A match with since==10 sets run++. A match otherwise sets run=1. Every match clears since.
  - No match with since==10 sets run=0.
  - When run reaches LOCK_COUNT, go to LOCKED, set wcnt=1 and data_run=0, assert locked.
- LOCKED state:
  - wcnt counts mod 10. The word-boundary cycle is wcnt==0, i.e. exactly 10 edges after the locking match and every 10 thereafter.
  - At a word boundary with a token: de=0, c1/c0 per table, d unchanged, data_run=0.
  - At a word boundary with a non-token: de=1, c0/c1 hold, data_run++.
  - Data decode: x = w[9] ? ~w[7:0] : w[7:0]. d[0]=x[0]. For i=1..7, d[i] = w[8] ? x[i]^x[i-1] : ~(x[i]^x[i-1]).
  - When data_run reaches MAX_DATA_RUN: go to SEARCH, locked=0, run=0, since=0. No word_valid for that word.
- Off-phase token matches while LOCKED are ignored.
- In SEARCH, word_valid stays 0 and de/d/c0/c1 hold their last values.

## Timing
- Reset values: word_valid=0, de=0, d=0, c0=0, c1=0, locked=0, err_cnt=0, state SEARCH, w=0, counters 0.
- Reset mid-operation drops lock within the same edge. No word_valid is emitted in the reset cycle.
- Decode latency: the 10th bit of a word is sampled at edge k. The registered outputs and word_valid appear after edge k+1. word_valid is high for exactly one tmds_clk cycle, with a period of 10 cycles.
- locked rises after the edge that follows the LOCK_COUNT-th matching edge. The first word_valid follows 10 cycles later.
- locked falls after the edge that evaluates the MAX_DATA_RUN-th data word.

## Configuration
- TMDS_DEC_ERR_CNT_EN defined:
  - err_cnt is present and increments by 1 on every LOCKED→SEARCH transition caused by MAX_DATA_RUN.
  - err_cnt saturates at 0xFFFF and is cleared only by rst.
- TMDS_DEC_ERR_CNT_EN undefined: the err_cnt port and counter do not exist, and all other behaviour is identical.

## Structure
- Shared package tmds_pkg holds:
  - the four control-token constants, which must match the encoder's table;
  - the word width (10);
  - the state enum {SEARCH, LOCKED}.
- One sub-module: tmds_word_decode. It is purely combinational: 10-bit word in; is_token, c1, c0, d[7:0] out. The encoder-side bench reuses it as a reference model.

## Test plan
1. rst held 3 cycles, then serial_in=0 for 100 cycles → all outputs 0, locked stays 0.
2. 8 back-to-back words 1101010100, sent LSB first → locked=1. Each following token word gives word_valid with de=0, c1=0, c0=1, every 10 cycles.
3. Locked, then send 0100000000 → d=0x00, de=1. Then send 1011111111 → d=0xFE, de=1.
4. 7 tokens, 1 data word, then 8 tokens → locked rises only after the 8th token of the second run.
5. MAX_DATA_RUN=16, locked, insert one extra bit, then data only → locked falls at the 16th data word and err_cnt=1 (macro on). Then 8 tokens at the new phase → relock.
6. rst pulsed for 1 cycle while locked and mid-word → locked=0 and word_valid=0 on the next cycle. Relock requires LOCK_COUNT fresh tokens.
